sseg_scan_decoder: RTL and testbench

SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

---
 rtl/sseg_pkg.sv | 28 ++
 rtl/sseg_hex_decode.sv | 22 ++
 rtl/sseg_scan_decoder.sv | 133 +++++++++++++
 tb/tb_sseg_scan_decoder.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan decoder: FSM states, the
// active-low hex segment table (also used by the display multiplexer) and the idle anode code.
package sseg_pkg;

    typedef enum logic [1:0] {StIdle, StSettling, StHeld} scan_state_e;

    localparam logic [3:0] AN_IDLE = 4'hF;

    // Active-low {dp, g..a} patterns for hex 0..F with dp off; index 0 is the LSB entry.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic an_one_cold(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!an[k]) idx = 2'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational reverse lookup of an active-low segment pattern to its hex value.
// The decimal point (bit 7) is ignored; valid_o is low when no table entry matches.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [7:0] pattern_i,
    output logic [3:0] value_o,
    output logic       valid_o
);

    always_comb begin
        value_o = 4'h0;
        valid_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i[6:0] == SEG_TABLE[i][6:0]) begin
                value_o = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sseg_scan_decoder.sv
// Recovers the four digit patterns from a scanned, multiplexed 7-segment bus.
// Optional hex decoding of the captured digits is compiled in with SSEG_HEX_DECODE_EN.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] an_i,
    input  logic [7:0] sseg_i,
    output logic [7:0] digit0_o,
    output logic [7:0] digit1_o,
    output logic [7:0] digit2_o,
    output logic [7:0] digit3_o,
    output logic       frame_valid_o,
    output logic       illegal_o,
    output logic       stale_o,
    output logic [3:0] hex0_o,
    output logic [3:0] hex1_o,
    output logic [3:0] hex2_o,
    output logic [3:0] hex3_o,
    output logic [3:0] hex_valid_o
);

    localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    CNT_MAX = 8'(SETTLE);
    localparam logic [7:0]    CNT_CAP = 8'(SETTLE - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    logic [3:0]      an_q;
    logic [7:0]      sseg_q;
    logic [7:0]      cnt_q, cnt_d;
    scan_state_e     state_q, state_d;
    logic [3:0]      seen_q, seen_d;
    logic [3:0][7:0] digit_q, digit_d;
    logic            frame_q, frame_d;
    logic            illegal_q, illegal_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            an_change;
    logic            capture;
    logic [1:0]      cap_idx;

    always_comb begin
        an_change = (an_i != an_q);
        // The SETTLE-th stable sample of the registered pattern completes the dwell.
        capture   = (state_q == StSettling) && (cnt_q == CNT_CAP) && an_one_cold(an_q);
        cap_idx   = an_index(an_q);

        if (an_change)              cnt_d = 8'd0;
        else if (cnt_q == CNT_MAX)  cnt_d = cnt_q;
        else                        cnt_d = cnt_q + 8'd1;

        state_d = state_q;
        unique case (state_q)
            StSettling:     if (capture) state_d = StHeld;
            StIdle, StHeld: state_d = state_q;
            default:        state_d = StIdle;
        endcase
        if (an_change) state_d = an_one_cold(an_i) ? StSettling : StIdle;

        illegal_d = an_change && (an_i != AN_IDLE) && !an_one_cold(an_i);

        digit_d = digit_q;
        if (capture) digit_d[cap_idx] = sseg_q;

        // A completed mask is reported and cleared one edge after the completing capture.
        frame_d = (seen_q == 4'hF);
        seen_d  = frame_d ? 4'h0 : seen_q;
        if (capture) seen_d[cap_idx] = 1'b1;

        if (capture)              tmo_d = '0;
        else if (tmo_q == TMO_MAX) tmo_d = tmo_q;
        else                      tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            an_q      <= AN_IDLE;
            sseg_q    <= 8'hFF;
            cnt_q     <= 8'd0;
            state_q   <= StIdle;
            seen_q    <= 4'h0;
            digit_q   <= {4{8'hFF}};
            frame_q   <= 1'b0;
            illegal_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            an_q      <= an_i;
            sseg_q    <= sseg_i;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            seen_q    <= seen_d;
            digit_q   <= digit_d;
            frame_q   <= frame_d;
            illegal_q <= illegal_d;
            tmo_q     <= tmo_d;
        end
    end

    assign digit0_o      = digit_q[0];
    assign digit1_o      = digit_q[1];
    assign digit2_o      = digit_q[2];
    assign digit3_o      = digit_q[3];
    assign frame_valid_o = frame_q;
    assign illegal_o     = illegal_q;
    assign stale_o       = (tmo_q == TMO_MAX);

`ifdef SSEG_HEX_DECODE_EN
    logic [3:0][3:0] hex_val;

    for (genvar k = 0; k < 4; k++) begin : g_hex
        sseg_hex_decode u_hex_decode (
            .pattern_i (digit_q[k]),
            .value_o   (hex_val[k]),
            .valid_o   (hex_valid_o[k])
        );
    end

    assign hex0_o = hex_val[0];
    assign hex1_o = hex_val[1];
    assign hex2_o = hex_val[2];
    assign hex3_o = hex_val[3];
`else
    assign hex0_o      = 4'h0;
    assign hex1_o      = 4'h0;
    assign hex2_o      = 4'h0;
    assign hex3_o      = 4'h0;
    assign hex_valid_o = 4'h0;
`endif

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Self-checking bench for sseg_scan_decoder: captures and frame pulses are predicted
// by a scoreboard when each anode dwell is driven and compared as the DUT produces them.
module tb_sseg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 16;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] an_i;
    logic [7:0] sseg_i;
    logic [7:0] digit0_o, digit1_o, digit2_o, digit3_o;
    logic       frame_valid_o, illegal_o, stale_o;
    logic [3:0] hex0_o, hex1_o, hex2_o, hex3_o, hex_valid_o;

    typedef struct {
        int         idx;
        logic [7:0] val;
    } cap_t;

    int         n_checks    = 0;
    int         n_fail      = 0;
    int         cyc         = 0;
    int         frame_cnt   = 0;
    int         illegal_cnt = 0;
    int         exp_cyc;
    cap_t       cap_q[$];
    int         frame_q[$];
    logic [7:0] exp_digit [4];
    logic [3:0] exp_seen;

    sseg_scan_decoder #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .an_i          (an_i),
        .sseg_i        (sseg_i),
        .digit0_o      (digit0_o),
        .digit1_o      (digit1_o),
        .digit2_o      (digit2_o),
        .digit3_o      (digit3_o),
        .frame_valid_o (frame_valid_o),
        .illegal_o     (illegal_o),
        .stale_o       (stale_o),
        .hex0_o        (hex0_o),
        .hex1_o        (hex1_o),
        .hex2_o        (hex2_o),
        .hex3_o        (hex3_o),
        .hex_valid_o   (hex_valid_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Frame pulses are popped from the scoreboard with their predicted cycle.
    always @(negedge clk_i) begin
        if (illegal_o === 1'b1) illegal_cnt++;
        if (frame_valid_o === 1'b1) begin
            frame_cnt++;
            n_checks++;
            if (frame_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                exp_cyc = frame_q.pop_front();
                if (cyc != exp_cyc) begin
                    n_fail++;
                    $display("FAIL frame_cycle: pulse at cycle %0d, expected %0d", cyc, exp_cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] dut_digit(input int k);
        case (k)
            0:       return digit0_o;
            1:       return digit1_o;
            2:       return digit2_o;
            default: return digit3_o;
        endcase
    endfunction

    // Drives one dwell and records what the DUT should produce from it.
    task automatic drive_dwell(input logic [3:0] an, input logic [7:0] seg, input int len);
        int idx;
        an_i   = an;
        sseg_i = seg;
        case (an)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
        endcase
        if (idx >= 0 && len >= SETTLE) begin
            cap_q.push_back('{idx, seg});
            exp_digit[idx] = seg;
            exp_seen[idx]  = 1'b1;
            if (exp_seen == 4'hF) begin
                frame_q.push_back(cyc + SETTLE + 2);
                exp_seen = 4'h0;
            end
        end
        step(len);
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        an_i   = 4'hF;
        sseg_i = 8'hFF;
        step(3);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dut_digit(k) !== 8'hFF) begin
                n_fail++;
                $display("FAIL reset_digit%0d: got %h, want ff", k, dut_digit(k));
            end
        end
        n_checks++;
        if ({frame_valid_o, illegal_o, stale_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got frame/illegal/stale %b, want 000",
                     {frame_valid_o, illegal_o, stale_o});
        end
        n_checks++;
        if (hex_valid_o !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_hex_valid: got %b, want 0000", hex_valid_o);
        end
`ifndef SSEG_HEX_DECODE_EN
        n_checks++;
        if ({hex3_o, hex2_o, hex1_o, hex0_o} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_hex: got %h, want 0000", {hex3_o, hex2_o, hex1_o, hex0_o});
        end
`endif
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) exp_digit[k] = 8'hFF;
        exp_seen = 4'h0;
        step(2);
    endtask

    task automatic test_full_scan;
        logic [3:0] an_tab [4];
        logic [7:0] seg_tab [4];
        cap_t       c;
        int         f0;
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
        f0 = frame_cnt;
        for (int i = 0; i < 4; i++) begin
            drive_dwell(an_tab[i], seg_tab[i], SETTLE);
            n_checks++;
            if (dut_digit(i) !== 8'hFF) begin
                n_fail++;
                $display("FAIL scan_early%0d: got %h one edge before capture, want ff",
                         i, dut_digit(i));
            end
            step(1);
            c = cap_q.pop_front();
            n_checks++;
            if (dut_digit(c.idx) !== c.val) begin
                n_fail++;
                $display("FAIL scan_capture%0d: got %h, want %h", c.idx, dut_digit(c.idx), c.val);
            end
            step(64 - SETTLE - 1);
        end
        n_checks++;
        if (frame_cnt - f0 != 1 || frame_q.size() != 0) begin
            n_fail++;
            $display("FAIL scan_frame_count: got %0d pulses (%0d pending), want 1",
                     frame_cnt - f0, frame_q.size());
        end
`ifdef SSEG_HEX_DECODE_EN
        n_checks++;
        if ({hex3_o, hex2_o, hex1_o, hex0_o} !== 16'h3210 || hex_valid_o !== 4'hF) begin
            n_fail++;
            $display("FAIL scan_hex: got %h valid %b, want 3210 valid 1111",
                     {hex3_o, hex2_o, hex1_o, hex0_o}, hex_valid_o);
        end
`else
        n_checks++;
        if ({hex3_o, hex2_o, hex1_o, hex0_o} !== 16'h0 || hex_valid_o !== 4'h0) begin
            n_fail++;
            $display("FAIL scan_hex_off: got %h valid %b, want 0000 valid 0000",
                     {hex3_o, hex2_o, hex1_o, hex0_o}, hex_valid_o);
        end
`endif
    endtask

    task automatic test_glitch;
        cap_t       c;
        int         f0;
        logic [3:0] an_tab [3];
        logic [7:0] seg_tab [3];
        an_tab  = '{4'b1110, 4'b1011, 4'b0111};
        seg_tab = '{8'h99, 8'h92, 8'h82};
        f0 = frame_cnt;
        drive_dwell(4'b1101, 8'h80, 2);
        drive_dwell(4'hF, 8'hFF, 10);
        n_checks++;
        if (digit1_o !== exp_digit[1]) begin
            n_fail++;
            $display("FAIL glitch_digit1: got %h, want %h", digit1_o, exp_digit[1]);
        end
        // Digit 1 is skipped: a glitch that set its seen bit would make a frame here.
        for (int i = 0; i < 3; i++) begin
            drive_dwell(an_tab[i], seg_tab[i], 20);
            c = cap_q.pop_front();
            n_checks++;
            if (dut_digit(c.idx) !== c.val) begin
                n_fail++;
                $display("FAIL glitch_capture%0d: got %h, want %h",
                         c.idx, dut_digit(c.idx), c.val);
            end
        end
        n_checks++;
        if (frame_cnt - f0 != 0) begin
            n_fail++;
            $display("FAIL glitch_no_frame: got %0d pulses, want 0", frame_cnt - f0);
        end
    endtask

    task automatic test_illegal;
        cap_t c;
        int   f0;
        int   il0;
        f0  = frame_cnt;
        il0 = illegal_cnt;
        drive_dwell(4'b1100, 8'h00, 10);
        drive_dwell(4'hF, 8'hFF, 5);
        n_checks++;
        if (illegal_cnt - il0 != 1) begin
            n_fail++;
            $display("FAIL illegal_pulses: got %0d, want 1", illegal_cnt - il0);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dut_digit(k) !== exp_digit[k]) begin
                n_fail++;
                $display("FAIL illegal_digit%0d: got %h, want %h", k, dut_digit(k), exp_digit[k]);
            end
        end
        drive_dwell(4'b1101, 8'hF8, 20);
        c = cap_q.pop_front();
        n_checks++;
        if (dut_digit(c.idx) !== c.val) begin
            n_fail++;
            $display("FAIL illegal_after_capture: got %h, want %h", dut_digit(c.idx), c.val);
        end
        n_checks++;
        if (frame_cnt - f0 != 1 || frame_q.size() != 0) begin
            n_fail++;
            $display("FAIL illegal_mask_kept: got %0d pulses, want 1", frame_cnt - f0);
        end
    endtask

    task automatic test_recapture;
        cap_t       c;
        int         f0;
        logic [3:0] an_tab [5];
        logic [7:0] seg_tab [5];
        an_tab  = '{4'b1110, 4'b1111, 4'b1110, 4'b1101, 4'b1011};
        seg_tab = '{8'h80, 8'hFF, 8'h90, 8'hF9, 8'hA4};
        f0 = frame_cnt;
        for (int i = 0; i < 5; i++) begin
            drive_dwell(an_tab[i], seg_tab[i], 20);
            if (an_tab[i] != 4'hF) begin
                c = cap_q.pop_front();
                n_checks++;
                if (dut_digit(c.idx) !== c.val) begin
                    n_fail++;
                    $display("FAIL recap_capture%0d: got %h, want %h",
                             c.idx, dut_digit(c.idx), c.val);
                end
            end
        end
        n_checks++;
        if (frame_cnt - f0 != 0) begin
            n_fail++;
            $display("FAIL recap_early_frame: got %0d pulses, want 0", frame_cnt - f0);
        end
        drive_dwell(4'b0111, 8'hB0, 20);
        c = cap_q.pop_front();
        n_checks++;
        if (digit3_o !== c.val || digit0_o !== 8'h90) begin
            n_fail++;
            $display("FAIL recap_digits: got d3 %h d0 %h, want %h 90", digit3_o, digit0_o, c.val);
        end
        n_checks++;
        if (frame_cnt - f0 != 1 || frame_q.size() != 0) begin
            n_fail++;
            $display("FAIL recap_frame: got %0d pulses, want 1", frame_cnt - f0);
        end
    endtask

    task automatic test_timeout;
        cap_t c;
        logic exp;
        drive_dwell(4'hF, 8'hFF, 3);
        drive_dwell(4'b1110, 8'hC0, SETTLE + 1);
        c = cap_q.pop_front();
        n_checks++;
        if (digit0_o !== c.val || stale_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_capture: got d0 %h stale %b, want %h 0", digit0_o, stale_o, c.val);
        end
        an_i   = 4'hF;
        sseg_i = 8'hFF;
        for (int j = 1; j <= 20; j++) begin
            step(1);
            exp = (j >= TIMEOUT);
            n_checks++;
            if (stale_o !== exp) begin
                n_fail++;
                $display("FAIL tmo_stale_cycle%0d: got %b, want %b", j, stale_o, exp);
            end
        end
        drive_dwell(4'b1101, 8'hA4, SETTLE);
        n_checks++;
        if (stale_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_before_capture: got %b, want 1", stale_o);
        end
        step(1);
        c = cap_q.pop_front();
        n_checks++;
        if (stale_o !== 1'b0 || digit1_o !== c.val) begin
            n_fail++;
            $display("FAIL tmo_clear: got stale %b d1 %h, want 0 %h", stale_o, digit1_o, c.val);
        end
    endtask

    task automatic test_reset_mid_dwell;
        drive_dwell(4'hF, 8'hFF, 20);
        n_checks++;
        if (stale_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rmd_stale_before: got %b, want 1", stale_o);
        end
        an_i   = 4'b1011;
        sseg_i = 8'h86;
        step(2);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({digit3_o, digit2_o, digit1_o, digit0_o} !== {4{8'hFF}} || stale_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rmd_async: got digits %h stale %b, want ffffffff 0",
                     {digit3_o, digit2_o, digit1_o, digit0_o}, stale_o);
        end
        step(2);
        rst_ni = 1'b1;
        cap_q.delete();
        for (int k = 0; k < 4; k++) exp_digit[k] = 8'hFF;
        exp_seen = 4'h0;
        step(SETTLE);
        n_checks++;
        if (digit2_o !== 8'hFF) begin
            n_fail++;
            $display("FAIL rmd_early: got %h, want ff", digit2_o);
        end
        step(1);
        exp_digit[2] = 8'h86;
        exp_seen[2]  = 1'b1;
        n_checks++;
        if (digit2_o !== exp_digit[2]) begin
            n_fail++;
            $display("FAIL rmd_capture: got %h, want %h", digit2_o, exp_digit[2]);
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_glitch();
        test_illegal();
        test_recapture();
        test_timeout();
        test_reset_mid_dwell();
        step(5);
        n_checks++;
        if (frame_q.size() != 0) begin
            n_fail++;
            $display("FAIL frame_pending: %0d expected pulses never seen, want 0", frame_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
